song_block_sequencer: RTL and testbench

SONG_BLOCK_SEQUENCER -- requirements
Module: song_block_sequencer

---
 rtl/song_block_sequencer.sv | 152 +++++++++++++++
 tb/tb_song_block_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/song_block_sequencer.sv
// Song block sequencer: walks a song's blocks, fetches each block's note count
// and plays it for count*TICKS_PER_BEAT beat ticks, with pause/stop control.
module song_block_sequencer #(
  parameter int FETCH_LAT      = 2,
  parameter int TICKS_PER_BEAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] song_sel_in,
  input  logic [8:0] song_len,
  input  logic       beat_tick,
  input  logic [2:0] block_size,
  output logic [8:0] block_idx,
  output logic [1:0] song_sel,
  output logic       note_valid,
  output logic       block_start,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  localparam int CW = $clog2(4 * TICKS_PER_BEAT + 1);
  localparam int TW = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    idx_q, idx_d;
  logic [8:0]    len_q, len_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          bs_q, bs_d;
  logic          advance;
  logic [2:0]    sat_size;

  assign sat_size = (block_size > 3'd4) ? 3'd4 : block_size;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    bs_d    = 1'b0;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          sel_d   = song_sel_in;
          len_d   = song_len;
          idx_d   = 9'd0;
          tmr_d   = '0;
          cnt_d   = '0;
          state_d = (song_len == 9'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        // block_size is only trusted in the final fetch cycle
        if (tmr_q == TW'(FETCH_LAT - 1)) begin
          if (block_size == 3'd0) begin
            advance = 1'b1;
          end else begin
            cnt_d   = CW'(sat_size) * CW'(TICKS_PER_BEAT);
            bs_d    = 1'b1;
            state_d = S_PLAY;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_PLAY: begin
        if (pause) begin
          state_d = S_PAUSED;
        end else if (beat_tick) begin
          if (cnt_q <= CW'(1)) advance = 1'b1;
          else                 cnt_d   = cnt_q - CW'(1);
        end
      end
      S_PAUSED: begin
        if (!pause) state_d = S_PLAY;
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = 9'd0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 9'd0;
      end
    endcase

    if (advance) begin
      if (idx_q == len_q - 9'd1) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 9'd1;
        tmr_d   = '0;
        state_d = S_FETCH;
      end
    end

    // stop overrides everything outside IDLE, including a same-cycle start
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d   = 9'd0;
      tmr_d   = '0;
      cnt_d   = '0;
      bs_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= 9'd0;
      len_q   <= 9'd0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      bs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      bs_q    <= bs_d;
    end
  end

  assign block_idx   = idx_q;
  assign song_sel    = sel_q;
  assign block_start = bs_q;
  assign note_valid  = (state_q == S_PLAY);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign state       = state_q;

endmodule

// File: tb/tb_song_block_sequencer.sv
// Directed bench for song_block_sequencer: block reader model, tick generator,
// and hand-computed expectations for playback, skip, pause, stop and reset.
module tb_song_block_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, pause, beat_tick;
  logic [1:0] song_sel_in;
  logic [8:0] song_len;
  logic [2:0] block_size;
  logic [8:0] block_idx;
  logic [1:0] song_sel;
  logic       note_valid, block_start, busy, done;
  logic [2:0] state;

  logic [2:0] sizes [8];
  int         n_checks = 0;
  int         n_errors = 0;
  int         tdiv = 0;
  int         bs_cnt, done_cnt, fetch_cnt, paused_ticks;
  int         ticks_blk [8];
  int         bs_idx [$];

  always #5 clk = ~clk;

  assign block_size = (block_idx < 9'd8) ? sizes[block_idx[2:0]] : 3'd0;

  song_block_sequencer #(.FETCH_LAT(2), .TICKS_PER_BEAT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .song_sel_in(song_sel_in), .song_len(song_len), .beat_tick(beat_tick),
    .block_size(block_size), .block_idx(block_idx), .song_sel(song_sel),
    .note_valid(note_valid), .block_start(block_start), .busy(busy),
    .done(done), .state(state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: observe outputs at the falling edge, then drive the tick.
  task automatic step();
    @(negedge clk);
    if (block_start) begin
      bs_cnt++;
      bs_idx.push_back(int'(block_idx));
    end
    if (done) done_cnt++;
    if (state == 3'd1) fetch_cnt++;
    tdiv = (tdiv == 4) ? 0 : tdiv + 1;
    beat_tick = (tdiv == 0);
    if (beat_tick && state == 3'd2 && !pause && block_idx < 9'd8)
      ticks_blk[block_idx[2:0]]++;
    if (beat_tick && state == 3'd3) paused_ticks++;
  endtask

  task automatic clear();
    bs_cnt = 0; done_cnt = 0; fetch_cnt = 0; paused_ticks = 0;
    bs_idx.delete();
    for (int i = 0; i < 8; i++) begin
      ticks_blk[i] = 0;
      sizes[i] = 3'd0;
    end
  endtask

  task automatic start_song(input logic [1:0] sel, input logic [8:0] len);
    song_sel_in = sel;
    song_len    = len;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic run_until_idle(input string tag);
    for (int i = 0; i < 1000; i++) begin
      step();
      if (state == 3'd0) break;
    end
    chk({tag, "_idle"}, int'(state), 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; beat_tick = 1'b0;
    song_sel_in = 2'd0; song_len = 9'd0;
    clear();
    step(); step();
    chk("rst_state", int'(state), 0);
    chk("rst_idx", int'(block_idx), 0);
    chk("rst_sel", int'(song_sel), 0);
    chk("rst_outs", int'({note_valid, block_start, busy, done}), 0);
    rst = 1'b1;
    step();

    // stop beats start in IDLE
    stop = 1'b1; start = 1'b1; song_len = 9'd3;
    step();
    chk("idle_stopwin_state", int'(state), 0);
    chk("idle_stopwin_busy", int'(busy), 0);
    stop = 1'b0; start = 1'b0;
    step();

    // three blocks of 4,2,1 notes; input changes while busy must be ignored
    clear();
    sizes[0] = 3'd4; sizes[1] = 3'd2; sizes[2] = 3'd1;
    start_song(2'd2, 9'd3);
    chk("s1_fetch", int'(state), 1);
    chk("s1_idx0", int'(block_idx), 0);
    song_sel_in = 2'd1; song_len = 9'd0;
    step();
    chk("s1_sel", int'(song_sel), 2);
    run_until_idle("s1");
    chk("s1_bs_cnt", bs_cnt, 3);
    chk("s1_ticks0", ticks_blk[0], 16);
    chk("s1_ticks1", ticks_blk[1], 8);
    chk("s1_ticks2", ticks_blk[2], 4);
    chk("s1_bsidx0", (bs_idx.size() > 0) ? bs_idx[0] : -1, 0);
    chk("s1_bsidx1", (bs_idx.size() > 1) ? bs_idx[1] : -1, 1);
    chk("s1_bsidx2", (bs_idx.size() > 2) ? bs_idx[2] : -1, 2);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_idx_end", int'(block_idx), 0);
    chk("s1_fetch_cycles", fetch_cnt, 6);

    // empty first block is skipped
    clear();
    sizes[0] = 3'd0; sizes[1] = 3'd3;
    start_song(2'd1, 9'd2);
    run_until_idle("s2");
    chk("s2_bs_cnt", bs_cnt, 1);
    chk("s2_bsidx", (bs_idx.size() > 0) ? bs_idx[0] : -1, 1);
    chk("s2_ticks0", ticks_blk[0], 0);
    chk("s2_ticks1", ticks_blk[1], 12);
    chk("s2_done_cnt", done_cnt, 1);

    // pause after 5 ticks of a 16-tick block
    clear();
    sizes[0] = 3'd4;
    start_song(2'd0, 9'd1);
    for (int i = 0; i < 300 && ticks_blk[0] < 5; i++) step();
    step();
    pause = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("s3_paused_state", int'(state), 3);
    chk("s3_paused_nv", int'(note_valid), 0);
    chk("s3_paused_idx", int'(block_idx), 0);
    chk("s3_paused_busy", int'(busy), 1);
    pause = 1'b0;
    run_until_idle("s3");
    chk("s3_after_ticks", ticks_blk[0] - 5, 11);
    chk("s3_bs_cnt", bs_cnt, 1);
    chk("s3_done_cnt", done_cnt, 1);

    // stop with start during PLAY
    clear();
    sizes[0] = 3'd4; sizes[1] = 3'd4; sizes[2] = 3'd4;
    start_song(2'd3, 9'd3);
    for (int i = 0; i < 300 && ticks_blk[0] < 3; i++) step();
    chk("s4_in_play", int'(state), 2);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("s4_state", int'(state), 0);
    chk("s4_idx", int'(block_idx), 0);
    chk("s4_outs", int'({note_valid, busy, done}), 0);
    step(); step(); step();
    chk("s4_no_done", done_cnt, 0);
    chk("s4_still_idle", int'(state), 0);

    // zero-length song goes straight to DONE
    clear();
    start_song(2'd1, 9'd0);
    chk("s5_done_state", int'(state), 4);
    chk("s5_done", int'(done), 1);
    chk("s5_idx", int'(block_idx), 0);
    step();
    chk("s5_idle", int'(state), 0);
    chk("s5_done_low", int'(done), 0);
    chk("s5_no_bs", bs_cnt, 0);

    // oversize block saturates to 4 notes
    clear();
    sizes[0] = 3'd7;
    start_song(2'd0, 9'd1);
    run_until_idle("s6");
    chk("s6_ticks", ticks_blk[0], 16);
    chk("s6_fetch_cycles", fetch_cnt, 2);
    chk("s6_done_cnt", done_cnt, 1);

    // reset mid-PLAY, then replay from block 0
    clear();
    sizes[0] = 3'd4; sizes[1] = 3'd4;
    start_song(2'd3, 9'd2);
    for (int i = 0; i < 300 && ticks_blk[0] < 2; i++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("s7_state", int'(state), 0);
    chk("s7_idx", int'(block_idx), 0);
    chk("s7_sel", int'(song_sel), 0);
    chk("s7_outs", int'({note_valid, block_start, busy, done}), 0);
    chk("s7_no_done", done_cnt, 0);
    clear();
    sizes[0] = 3'd4; sizes[1] = 3'd4;
    start_song(2'd1, 9'd2);
    run_until_idle("s7r");
    chk("s7r_bsidx0", (bs_idx.size() > 0) ? bs_idx[0] : -1, 0);
    chk("s7r_bs_cnt", bs_cnt, 2);
    chk("s7r_ticks1", ticks_blk[1], 16);
    chk("s7r_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
